// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - debounced push-button level with press, release and long-press pulses
//
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   btn_in        in   raw asynchronous button pin
//   pressed       out  debounced level, 1 = button held
//   press_pulse   out  one-cycle pulse when a press is accepted
//   release_pulse out  one-cycle pulse when a release is accepted
//   long_pulse    out  one-cycle pulse once a press has been held for LONG_MS
//
// Optional feature macro: BUTTON_LONG_PRESS_EN builds the hold counter and
// long_pulse logic; when undefined, long_pulse is tied to 0.
module button_debounce #(
    parameter int CLOCK_MHZ   = 27,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam longint DB_PROD   = longint'(CLOCK_MHZ) * 1000 * longint'(DEBOUNCE_MS);
    localparam longint LONG_PROD = longint'(CLOCK_MHZ) * 1000 * longint'(LONG_MS);

    localparam int DB_CYCLES = (DB_PROD < 1) ? 1 : int'(DB_PROD);
    localparam int DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Pin level while the button is not pressed.
    localparam logic PIN_IDLE = ACTIVE_LOW;

    // Counter arithmetic is 32-bit signed; larger products would wrap.
    if (DB_PROD >= 64'sh8000_0000 || LONG_PROD >= 64'sh8000_0000) begin : g_bad_timing
        $error("button_debounce: CLOCK_MHZ*1000*ms product must be below 2^31");
    end

    typedef enum logic [1:0] {
        RELEASED,
        ARM_PRESS,
        HELD,
        ARM_RELEASE
    } state_t;

    state_t          state;
    logic [DB_W-1:0] db_cnt;
    logic            sync1;
    logic            sync2;
    logic            s;

    // Two-flop synchronizer; resetting to the idle pin level keeps a
    // button held through reset from looking pressed until it is re-sampled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= PIN_IDLE;
            sync2 <= PIN_IDLE;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Normalized sample: 1 = pressed regardless of pin polarity.
    assign s = sync2 ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RELEASED;
            db_cnt        <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (s) begin
                        state  <= ARM_PRESS;
                        db_cnt <= '0;
                    end
                end
                ARM_PRESS: begin
                    if (!s) begin
                        state  <= RELEASED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= HELD;
                        db_cnt      <= '0;
                        pressed     <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state  <= ARM_RELEASE;
                        db_cnt <= '0;
                    end
                end
                ARM_RELEASE: begin
                    if (s) begin
                        state  <= HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= RELEASED;
                        db_cnt        <= '0;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= RELEASED;
                    db_cnt <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int LONG_CYCLES = (LONG_PROD < 1) ? 1 : int'(LONG_PROD);
    localparam int LONG_W      = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] hold_cnt;
    logic              long_fired;
    logic              press_done;
    logic              release_done;
    logic              holding;

    assign press_done   = (state == ARM_PRESS) && s && (db_cnt == DB_LAST);
    assign release_done = (state == ARM_RELEASE) && !s && (db_cnt == DB_LAST);
    // ARM_RELEASE still counts so release bounce does not restart the hold time.
    assign holding      = (state == HELD) || (state == ARM_RELEASE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            long_fired <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (press_done) begin
                hold_cnt   <= '0;
                long_fired <= 1'b0;
            end else if (holding) begin
                if (hold_cnt != LONG_LAST) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                // A release completing on the same edge takes priority.
                if (hold_cnt == LONG_LAST && !long_fired && !release_done) begin
                    long_pulse <= 1'b1;
                    long_fired <= 1'b1;
                end
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - randomized scoreboard bench for button_debounce
module tb_button_debounce;

    localparam int DB   = 1000;
    localparam int LONG = 3000;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_in;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    button_debounce #(
        .CLOCK_MHZ  (1),
        .DEBOUNCE_MS(1),
        .LONG_MS    (3),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    // Reference model: the accepted level flips once the sample has disagreed
    // with it for DB+1 consecutive clock edges; the sample lags the pin by two
    // edges. A long event is due LONG edges after a press unless a release is
    // accepted on or before that edge.
    logic [1:0] m_pipe;
    bit         m_pressed;
    int         m_run;
    int         m_long_due;
    bit         m_in_reset;

    always @(posedge clk) begin
        bit smp;
        cyc++;
        if (!rst_n) begin
            m_pipe     = 2'b11;
            m_pressed  = 1'b0;
            m_run      = 0;
            m_long_due = -1;
            m_in_reset = 1'b1;
        end else begin
            m_in_reset = 1'b0;
            smp = ~m_pipe[1];
            if (smp != m_pressed) m_run++;
            else m_run = 0;
            if (m_run == DB + 1) begin
                m_pressed = smp;
                m_run     = 0;
                if (smp) begin
                    exp_q.push_back('{EV_PRESS, cyc});
                    m_long_due = cyc + LONG;
                end else begin
                    exp_q.push_back('{EV_RELEASE, cyc});
                    m_long_due = -1;
                end
            end
            if (m_long_due == cyc) begin
`ifdef BUTTON_LONG_PRESS_EN
                exp_q.push_back('{EV_LONG, cyc});
`endif
                m_long_due = -1;
            end
            m_pipe = {m_pipe[0], btn_in};
        end
    end

    task automatic check_pulse(input logic p, input ev_kind_t k, input string name);
        if (p === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL %s: unexpected pulse at cycle %0d, none expected", name, cyc);
            end else if (exp_q[0].kind != k || exp_q[0].cyc != cyc) begin
                fails++;
                $display("FAIL %s: pulse at cycle %0d, expected %s at cycle %0d",
                         name, cyc, exp_q[0].kind.name(), exp_q[0].cyc);
            end else begin
                void'(exp_q.pop_front());
            end
        end
    endtask

    // Monitor: pops expected events as the DUT pulses, sampled at negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL missed_%s: no pulse seen at cycle %0d (now %0d)",
                     exp_q[0].kind.name(), exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (m_in_reset) begin
            tests++;
            if ({pressed, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_outputs: got %b, required 0000 at cycle %0d",
                         {pressed, press_pulse, release_pulse, long_pulse}, cyc);
            end
        end
        check_pulse(press_pulse, EV_PRESS, "press_pulse");
        check_pulse(release_pulse, EV_RELEASE, "release_pulse");
        check_pulse(long_pulse, EV_LONG, "long_pulse");
        tests++;
        if (pressed !== m_pressed) begin
            fails++;
            $display("FAIL pressed_level: got %b, required %b at cycle %0d", pressed, m_pressed, cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_level(input string name, input logic exp);
        tests++;
        if (pressed !== exp) begin
            fails++;
            $display("FAIL %s: pressed=%b, required %b", name, pressed, exp);
        end
    endtask

    initial begin
        int lens[3];
        rst_n  = 1'b0;
        btn_in = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(200);
        expect_level("idle_after_reset", 1'b0);

        // Clean press and release
        btn_in = 1'b0;
        idle(1500);
        expect_level("clean_press", 1'b1);
        btn_in = 1'b1;
        idle(1500);
        expect_level("clean_release", 1'b0);

        // Bounce every 300 cycles, then settle pressed
        for (int i = 0; i < 17; i++) begin
            btn_in = ~btn_in;
            idle(300);
        end
        btn_in = 1'b0;
        idle(1500);
        expect_level("bounce_settled", 1'b1);
        btn_in = 1'b1;
        idle(1500);

        // Glitch shorter than the debounce time
        btn_in = 1'b0;
        idle(999);
        btn_in = 1'b1;
        idle(1500);
        expect_level("glitch_rejected", 1'b0);

        // Long press
        btn_in = 1'b0;
        idle(5000);
        expect_level("long_hold", 1'b1);
        btn_in = 1'b1;
        idle(1500);

        // Release completing around the long threshold (3000 = same edge)
        lens[0] = LONG - 1;
        lens[1] = LONG;
        lens[2] = LONG + 1;
        foreach (lens[i]) begin
            btn_in = 1'b0;
            idle(lens[i]);
            btn_in = 1'b1;
            idle(1500);
        end

        // Reset while held
        btn_in = 1'b0;
        idle(1500);
        expect_level("before_reset", 1'b1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1500);
        expect_level("redetect_after_reset", 1'b1);
        btn_in = 1'b1;
        idle(1500);

        // Randomized segments around the debounce and long boundaries
        for (int i = 0; i < 20; i++) begin
            int cls;
            int len;
            cls = int'($urandom_range(0, 3));
            case (cls)
                0:       len = int'($urandom_range(1, 200));
                1:       len = int'($urandom_range(DB - 100, DB + 100));
                2:       len = int'($urandom_range(1, LONG));
                default: len = int'($urandom_range(LONG - 100, LONG + 100));
            endcase
            btn_in = ~btn_in;
            idle(len);
        end

        btn_in = 1'b1;
        idle(1500);
        expect_level("final_released", 1'b0);
        idle(10);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drained: %0d events outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
